seg_scan_scheduler: RTL and testbench

- Time-multiplexing controller for the 4-digit common-anode seven-segment display.
- Accepts a 16-bit BCD word from a producer (counter, status logic) over a valid/ready handshake.
- Updates the display only at frame boundaries, so the display never tears.
- Scans one digit per slot, with a guard interval against ghosting, leading-zero blanking, and a frame-done strobe.

---
 rtl/seg_scan_scheduler.sv | 178 +++++++++++++++++
 tb/tb_seg_scan_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: 4-digit common-anode seven-segment scan controller.
// Accepts BCD words over valid/ready into a one-deep pending buffer and
// commits them to the displayed word only at frame boundaries, so a frame
// never mixes two words. Each digit slot starts with an all-anodes-off
// guard interval. Optional build macro SEG_SCAN_DIM_EN adds a 4-bit
// frame-duty brightness control on port bright.
module seg_scan_scheduler #(
  parameter int CLK_DIV = 100000,
  parameter int DIV_W   = 17,
  parameter int GUARD   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic        wr_lzb,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]  bright,
`endif
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] SC_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] SC_GUARD = DIV_W'(GUARD);

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

  buf_state_t       buf_state;
  buf_state_t       buf_next;
  logic             commit;

  logic [DIV_W-1:0] sc;
  logic [1:0]       d;
  logic             tick;
  logic             boundary;
  logic             xfer;

  logic [15:0]      pend_word;
  logic             pend_lzb;
  logic [15:0]      active_word;
  logic             active_lzb;

  logic [15:0]      shifted;
  logic [3:0]       cur_nib;
  logic             lead_blank;
  logic [6:0]       cur_pat;
  logic             frame_en;

  assign tick     = (sc == SC_LAST);
  assign boundary = tick && (d == 2'd3);
  assign xfer     = wr_valid && wr_ready;

  // Active-low a..g patterns for BCD; non-BCD nibbles are blanked.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // Pending-buffer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) buf_state <= BUF_EMPTY;
    else       buf_state <= buf_next;
  end

  // Buffer next state: a word is only accepted while empty, and a full
  // buffer drains into the active word at the frame boundary. A transfer
  // coinciding with a boundary therefore lands in pending only.
  always_comb begin
    buf_next = buf_state;
    commit   = 1'b0;
    case (buf_state)
      BUF_EMPTY: if (xfer) buf_next = BUF_FULL;
      BUF_FULL: begin
        if (boundary) begin
          buf_next = BUF_EMPTY;
          commit   = 1'b1;
        end
      end
      default: buf_next = BUF_EMPTY;
    endcase
  end

  // Registered ready mirrors the buffer being empty next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_ready <= 1'b1;
    else       wr_ready <= (buf_next == BUF_EMPTY);
  end

  // Capture the producer word and its blanking flag on transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_word <= 16'h0000;
      pend_lzb  <= 1'b0;
    end else if (xfer) begin
      pend_word <= wr_data;
      pend_lzb  <= wr_lzb;
    end
  end

  // Active word only changes at a boundary, keeping each frame consistent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_word <= 16'h0000;
      active_lzb  <= 1'b0;
    end else if (commit) begin
      active_word <= pend_word;
      active_lzb  <= pend_lzb;
    end
  end

  // Slot counter and digit index, rightmost digit scanned first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc <= '0;
      d  <= 2'd0;
    end else if (tick) begin
      sc <= '0;
      d  <= d + 2'd1;
    end else begin
      sc <= sc + DIV_W'(1);
    end
  end

  // Current digit's nibble; it is a leading zero when it and everything to
  // its left are zero (digit 0 is never blanked).
  assign shifted    = active_word >> {d, 2'b00};
  assign cur_nib    = shifted[3:0];
  assign lead_blank = active_lzb && (d != 2'd0) && (shifted == 16'h0000);
  assign cur_pat    = lead_blank ? 7'h7F : seg_decode(cur_nib);

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] fc;
  logic [3:0] bright_q;

  // Frame counter and brightness sample, both advanced at the boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fc       <= 4'd0;
      bright_q <= 4'hF;
    end else if (boundary) begin
      fc       <= fc + 4'd1;
      bright_q <= bright;
    end
  end

  assign frame_en = (fc <= bright_q);
`else
  assign frame_en = 1'b1;
`endif

  // Output stage: one cycle behind sc/d; cathode is preloaded during guard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode      <= 4'hF;
      cathode    <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      anode      <= ((sc < SC_GUARD) || !frame_en) ? 4'hF : ~(4'b0001 << d);
      cathode    <= cur_pat;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Testbench for seg_scan_scheduler: directed and random producer traffic
// against a time-indexed reference model of the scan and commit behaviour.
module tb_seg_scan_scheduler;

  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_lzb = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        frame_done;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]  bright = 4'hF;
`endif

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  seg_scan_scheduler #(.CLK_DIV(CLK_DIV), .DIV_W(4), .GUARD(GUARD)) dut (
    .clk(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .wr_lzb(wr_lzb),
`ifdef SEG_SCAN_DIM_EN
    .bright(bright),
`endif
    .anode(anode),
    .cathode(cathode),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pattern shown for digit k of a word: leading zeros blank when lzb set.
  function automatic logic [6:0] digit_pat(input logic [15:0] w, input logic lzb, input int k);
    logic [15:0] rest;
    rest = w >> (4 * k);
    if (lzb && k > 0 && rest == 16'h0000) return 7'h7F;
    case (rest[3:0])
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model: n = clock edges since reset; slot and digit follow
  // directly from n, and the buffer holds at most one word until the next
  // frame boundary.
  int          n = 0;
  logic [15:0] m_act = 16'h0000;
  logic        m_lzb = 1'b0;
  logic [15:0] m_pend = 16'h0000;
  logic        m_plzb = 1'b0;
  logic        m_pending = 1'b0;
  logic        acc_flag = 1'b0;
  logic [3:0]  exp_anode = 4'hF;
  logic [6:0]  exp_cathode = 7'h7F;
  logic        exp_fd = 1'b0;
  logic        exp_ready = 1'b1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n           <= 0;
      m_act       <= 16'h0000;
      m_lzb       <= 1'b0;
      m_pending   <= 1'b0;
      acc_flag    <= 1'b0;
      exp_anode   <= 4'hF;
      exp_cathode <= 7'h7F;
      exp_fd      <= 1'b0;
      exp_ready   <= 1'b1;
    end else begin
      exp_anode   <= ((n % CLK_DIV) < GUARD) ? 4'hF : ~(4'b0001 << ((n / CLK_DIV) % 4));
      exp_cathode <= digit_pat(m_act, m_lzb, (n / CLK_DIV) % 4);
      exp_fd      <= ((n % FRAME) == FRAME - 1);
      acc_flag    <= wr_valid && !m_pending;
      if (wr_valid && !m_pending) begin
        m_pend    <= wr_data;
        m_plzb    <= wr_lzb;
        m_pending <= 1'b1;
        exp_ready <= 1'b0;
        $display("XFER  t=%0t word=%h lzb=%0d", $time, wr_data, wr_lzb);
      end else if (((n % FRAME) == FRAME - 1) && m_pending) begin
        m_act     <= m_pend;
        m_lzb     <= m_plzb;
        m_pending <= 1'b0;
        exp_ready <= 1'b1;
        $display("COMMIT t=%0t word=%h lzb=%0d", $time, m_pend, m_plzb);
      end
      n <= n + 1;
    end
  end

  // Compare all outputs every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("anode", {12'h0, anode}, {12'h0, exp_anode});
      check("cathode", {9'h0, cathode}, {9'h0, exp_cathode});
      check("frame_done", {15'h0, frame_done}, {15'h0, exp_fd});
      check("wr_ready", {15'h0, wr_ready}, {15'h0, exp_ready});
    end
  end

  // Present a word and hold it until accepted; valid stays high afterwards.
  task automatic send(input logic [15:0] w, input logic l);
    bit done;
    done = 1'b0;
    wr_valid = 1'b1;
    wr_data  = w;
    wr_lzb   = l;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      @(negedge clk);
      if (acc_flag) done = 1'b1;
    end
    if (!done) check("send_timeout", 16'h0, 16'h1);
  endtask

  task automatic idle(input int cycles);
    wr_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'h0000;
    for (int k = 0; k < 4; k++)
      if ($urandom_range(0, 2) != 0) w[4*k +: 4] = 4'($urandom_range(0, 15));
    return w;
  endfunction

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_anode", {12'h0, anode}, 16'h000F);
    check("rst_cathode", {9'h0, cathode}, 16'h007F);
    check("rst_fd", {15'h0, frame_done}, 16'h0000);
    check("rst_ready", {15'h0, wr_ready}, 16'h0001);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed words from the plan, including blanking and back-to-back.
    idle(5);
    send(16'h1234, 1'b0);
    idle(3 * FRAME);
    send(16'h0007, 1'b1);
    idle(2 * FRAME);
    send(16'h0000, 1'b1);
    idle(2 * FRAME);
    send(16'h5678, 1'b0);
    send(16'h9012, 1'b0);
    send(16'h3456, 1'b1);
    idle(3 * FRAME);

    // Transfer in the same cycle as a boundary.
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
        @(negedge clk);
        if (!m_pending && (n % FRAME) == FRAME - 1) hit = 1'b1;
      end
      if (!hit) check("bnd_align", 16'h0, 16'h1);
      send(16'h12C4, 1'b0);
      check("bnd_fd", {15'h0, frame_done}, 16'h0001);
      check("bnd_ready", {15'h0, wr_ready}, 16'h0000);
      idle(3 * FRAME);
    end

    // Random producer traffic.
    for (int t = 0; t < 60; t++) begin
      send(rand_word(), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 40));
    end
    idle(2 * FRAME);

    // Reset mid-slot while a word is pending.
    send(16'h9876, 1'b0);
    idle(3);
    check("mrst_pending", {15'h0, wr_ready}, 16'h0000);
    #2 reset = 1'b1;
    #1;
    check("mrst_anode", {12'h0, anode}, 16'h000F);
    check("mrst_cathode", {9'h0, cathode}, 16'h007F);
    check("mrst_fd", {15'h0, frame_done}, 16'h0000);
    check("mrst_ready", {15'h0, wr_ready}, 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    idle(3 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
